// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline sequencing controller for the 5-stage core. It tracks the destination
// registers of the instructions in EX, MEM and WB in a 3-entry scoreboard. It
// detects RAW hazards for the instruction in ID, and it drives the PC and IF/ID
// write enables, the ID/EX bubble, and the IF/ID flush for a taken branch that
// resolves in EX. It also keeps saturating stall/flush counters and a sticky
// watchdog flag that trips when a stall run lasts too long.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   id_valid     ID holds a real instruction
//   id_rs/id_rt  ID source registers
//   id_use_rs/id_use_rt  ID instruction reads rs / rt
//   id_wreg      ID instruction writes the register file
//   id_destR     ID destination register
//   ex_branch    EX holds a branch
//   ex_zero      EX compare result (taken = ex_branch & ex_zero)
//   pc_wen       PC write enable
//   ifid_wen     IF/ID write enable
//   ifid_flush   load NOP into IF/ID
//   idex_bubble  load NOP into ID/EX
//   stall_cnt    saturating count of stall cycles
//   flush_cnt    saturating count of taken-branch flushes
//   stall_err    sticky flag: a stall run exceeded MAX_STALL cycles
module hazard_stall_ctrl #(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic [4:0]       id_destR,
    input  logic             ex_branch,
    input  logic             ex_zero,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_err
);

    // The run counter only has to count one past the limit, because that is
    // where the watchdog trips. After that it saturates.
    localparam int                RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0]  RUN_LIM = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0]  RUN_TOP = RUN_W'(MAX_STALL + 1);

    logic             sb0_v, sb1_v, sb2_v;
    logic [4:0]       sb0_dest, sb1_dest, sb2_dest;
    logic [RUN_W-1:0] run_len;

    logic match_rs, match_rt;
    logic hazard, flush, stall, issue;

    function automatic logic sb_match(
        input logic [4:0] r,
        input logic       v0, input logic [4:0] d0,
        input logic       v1, input logic [4:0] d1,
        input logic       v2, input logic [4:0] d2
    );
        // With a write-first register file the WB result is already visible
        // to the ID read, so the WB entry only matters when there is no bypass.
        return (r != 5'd0) &&
               ((v0 && (d0 == r)) ||
                (v1 && (d1 == r)) ||
                (!WB_BYPASS && v2 && (d2 == r)));
    endfunction

    always_comb begin
        match_rs = sb_match(id_rs, sb0_v, sb0_dest, sb1_v, sb1_dest, sb2_v, sb2_dest);
        match_rt = sb_match(id_rt, sb0_v, sb0_dest, sb1_v, sb1_dest, sb2_v, sb2_dest);
        hazard   = id_valid && ((id_use_rs && match_rs) || (id_use_rt && match_rt));
        flush    = ex_branch && ex_zero;
        // The ID instruction is squashed by a taken branch anyway, so there is
        // no point in stalling it.
        stall    = hazard && !flush;
        issue    = id_valid && !stall && !flush;
    end

    assign pc_wen      = !stall;
    assign ifid_wen    = !stall;
    assign ifid_flush  = flush;
    assign idex_bubble = stall || flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb0_v    <= 1'b0;
            sb0_dest <= 5'd0;
            sb1_v    <= 1'b0;
            sb1_dest <= 5'd0;
            sb2_v    <= 1'b0;
            sb2_dest <= 5'd0;
        end else begin
            sb2_v    <= sb1_v;
            sb2_dest <= sb1_dest;
            sb1_v    <= sb0_v;
            sb1_dest <= sb0_dest;
            if (issue) begin
                // Writes to $0 are discarded, so they are never tracked.
                sb0_v    <= id_wreg && (id_destR != 5'd0);
                sb0_dest <= id_destR;
            end else begin
                sb0_v    <= 1'b0;
                sb0_dest <= 5'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_len   <= '0;
            stall_err <= 1'b0;
        end else if (stall) begin
            if (run_len != RUN_TOP)
                run_len <= run_len + RUN_W'(1);
            // This stall takes the run to run_len+1, which is past the limit.
            if (run_len >= RUN_LIM)
                stall_err <= 1'b1;
        end else begin
            run_len <= '0;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, id_valid, id_use_rs, id_use_rt, id_wreg, ex_branch, ex_zero;
    logic [4:0] id_rs, id_rt, id_destR;

    logic        pc_wen0, ifid_wen0, ifid_flush0, idex_bubble0, stall_err0;
    logic [15:0] stall_cnt0, flush_cnt0;
    logic        pc_wen1, ifid_wen1, ifid_flush1, idex_bubble1, stall_err1;
    logic [3:0]  stall_cnt1, flush_cnt1;

    hazard_stall_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_destR(id_destR),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .pc_wen(pc_wen0), .ifid_wen(ifid_wen0),
        .ifid_flush(ifid_flush0), .idex_bubble(idex_bubble0), .stall_cnt(stall_cnt0),
        .flush_cnt(flush_cnt0), .stall_err(stall_err0)
    );

    hazard_stall_ctrl #(.WB_BYPASS(1'b0), .CNT_W(4), .MAX_STALL(2)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_destR(id_destR),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .pc_wen(pc_wen1), .ifid_wen(ifid_wen1),
        .ifid_flush(ifid_flush1), .idex_bubble(idex_bubble1), .stall_cnt(stall_cnt1),
        .flush_cnt(flush_cnt1), .stall_err(stall_err1)
    );

    typedef struct {
        logic        rst_n, valid;
        logic [4:0]  rs, rt;
        logic        urs, urt, wreg;
        logic [4:0]  dest;
        logic        br, z;
        logic        e_pc, e_flush, e_bub;
        logic        chk_cnt;
        logic [15:0] e_scnt, e_fcnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(
        input logic r, input logic v, input int rs, input int rt,
        input logic urs, input logic urt, input logic wr, input int d,
        input logic br, input logic z,
        input logic pc, input logic fl, input logic bub,
        input logic cc, input int sc, input int fc, input logic er
    );
        vec_t t;
        t.rst_n = r;  t.valid = v;  t.rs = 5'(rs);  t.rt = 5'(rt);
        t.urs = urs;  t.urt = urt;  t.wreg = wr;    t.dest = 5'(d);
        t.br = br;    t.z = z;
        t.e_pc = pc;  t.e_flush = fl;  t.e_bub = bub;
        t.chk_cnt = cc;  t.e_scnt = 16'(sc);  t.e_fcnt = 16'(fc);  t.e_err = er;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input int rs, input int rt,
                       input logic urs, input logic urt, input int d);
        @(negedge clk);
        rst_n = r;  id_valid = v;  id_rs = 5'(rs);  id_rt = 5'(rt);
        id_use_rs = urs;  id_use_rt = urt;  id_wreg = 1'b1;  id_destR = 5'(d);
        ex_branch = 1'b0;  ex_zero = 1'b0;
        #1;
    endtask

    function automatic int sat15(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
        id_use_rt = 1'b0; id_wreg = 1'b0; id_destR = '0; ex_branch = 1'b0; ex_zero = 1'b0;

        // Directed trace for u0 (WB_BYPASS=1). Expected counters are the values
        // seen during the cycle, i.e. before that cycle's edge.
        //            rst v  rs rt urs urt wr dst br z   pc fl bub cc sc fc er
        vecs.push_back(mk(0,0, 0, 0, 0, 0, 0, 0, 0,0,  1, 0, 0,  0, 0, 0, 0)); // reset
        vecs.push_back(mk(0,0, 0, 0, 0, 0, 0, 0, 0,0,  1, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(1,1, 1, 2, 1, 1, 1, 3, 0,0,  1, 0, 0,  1, 0, 0, 0)); // add $3
        vecs.push_back(mk(1,1, 3, 5, 1, 0, 1, 4, 0,0,  0, 0, 1,  1, 0, 0, 0)); // sub rs=$3
        vecs.push_back(mk(1,1, 3, 5, 1, 0, 1, 4, 0,0,  0, 0, 1,  1, 1, 0, 0));
        vecs.push_back(mk(1,1, 3, 5, 1, 0, 1, 4, 0,0,  1, 0, 0,  1, 2, 0, 0)); // issues
        vecs.push_back(mk(1,1, 1, 1, 1, 1, 1, 3, 0,0,  1, 0, 0,  1, 2, 0, 0)); // producer $3
        vecs.push_back(mk(1,1, 7, 8, 1, 1, 1, 6, 0,0,  1, 0, 0,  1, 2, 0, 0)); // independent
        vecs.push_back(mk(1,1, 9, 3, 1, 1, 1,10, 0,0,  0, 0, 1,  1, 2, 0, 0)); // rt=$3, 1 stall
        vecs.push_back(mk(1,1, 9, 3, 1, 1, 1,10, 0,0,  1, 0, 0,  1, 3, 0, 0));
        vecs.push_back(mk(1,1, 1, 2, 1, 1, 1, 0, 0,0,  1, 0, 0,  1, 3, 0, 0)); // writes $0
        vecs.push_back(mk(1,1, 0, 0, 1, 1, 1,11, 0,0,  1, 0, 0,  1, 3, 0, 0)); // reads $0
        vecs.push_back(mk(1,1, 1, 1, 1, 1, 1, 3, 0,0,  1, 0, 0,  1, 3, 0, 0)); // producer $3
        vecs.push_back(mk(1,1, 3, 0, 1, 0, 1,12, 1,1,  1, 1, 1,  1, 3, 0, 0)); // hazard+flush
        vecs.push_back(mk(1,0, 0, 0, 0, 0, 0, 0, 0,0,  1, 0, 0,  1, 3, 1, 0)); // squashed slot
        vecs.push_back(mk(1,1, 3, 0, 1, 0, 1,13, 1,0,  1, 0, 0,  1, 3, 1, 0)); // not taken
        vecs.push_back(mk(1,1, 1, 2, 1, 1, 1, 5, 0,0,  1, 0, 0,  1, 3, 1, 0)); // producer $5
        vecs.push_back(mk(1,1, 5, 0, 1, 0, 1,14, 0,0,  0, 0, 1,  1, 3, 1, 0)); // stall 1
        vecs.push_back(mk(0,1, 5, 0, 1, 0, 1,14, 0,0,  0, 0, 1,  1, 4, 1, 0)); // reset in stall 2
        vecs.push_back(mk(1,1, 5, 0, 1, 0, 1,14, 0,0,  1, 0, 0,  1, 0, 0, 0)); // stall cleared
        vecs.push_back(mk(1,0,14, 0, 1, 0, 0, 0, 0,0,  1, 0, 0,  1, 0, 0, 0)); // invalid ID
        vecs.push_back(mk(1,1,14, 0, 1, 0, 1,15, 0,0,  0, 0, 1,  1, 0, 0, 0)); // 2 back: 1 stall
        vecs.push_back(mk(1,1,14, 0, 1, 0, 1,15, 0,0,  1, 0, 0,  1, 1, 0, 0));
        vecs.push_back(mk(1,0, 0, 0, 0, 0, 0, 0, 1,1,  1, 1, 1,  1, 1, 0, 0)); // plain flush
        vecs.push_back(mk(1,0, 0, 0, 0, 0, 0, 0, 0,0,  1, 0, 0,  1, 1, 1, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;  id_valid = vecs[i].valid;
            id_rs = vecs[i].rs;     id_rt = vecs[i].rt;
            id_use_rs = vecs[i].urs;  id_use_rt = vecs[i].urt;
            id_wreg = vecs[i].wreg;   id_destR = vecs[i].dest;
            ex_branch = vecs[i].br;   ex_zero = vecs[i].z;
            #1;
            chk($sformatf("v%0d pc_wen", i),      32'(pc_wen0),      32'(vecs[i].e_pc));
            chk($sformatf("v%0d ifid_wen", i),    32'(ifid_wen0),    32'(vecs[i].e_pc));
            chk($sformatf("v%0d ifid_flush", i),  32'(ifid_flush0),  32'(vecs[i].e_flush));
            chk($sformatf("v%0d idex_bubble", i), 32'(idex_bubble0), 32'(vecs[i].e_bub));
            if (vecs[i].chk_cnt) begin
                chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt0), 32'(vecs[i].e_scnt));
                chk($sformatf("v%0d flush_cnt", i), 32'(flush_cnt0), 32'(vecs[i].e_fcnt));
                chk($sformatf("v%0d stall_err", i), 32'(stall_err0), 32'(vecs[i].e_err));
            end
        end

        // u1: WB_BYPASS=0, CNT_W=4, MAX_STALL=2. A back-to-back dependency now
        // stalls 3 cycles, which trips the watchdog, and six of them saturate
        // the counter.
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("u1 reset stall_cnt", 32'(stall_cnt1), 32'd0);
        chk("u1 reset stall_err", 32'(stall_err1), 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(1, 1, 1, 2, 1, 1, 3);
            chk($sformatf("u1 k%0d producer pc_wen", k), 32'(pc_wen1), 32'd1);
            for (int j = 0; j < 3; j++) begin
                cyc(1, 1, 3, 0, 1, 0, 4);
                chk($sformatf("u1 k%0d s%0d pc_wen", k, j), 32'(pc_wen1), 32'd0);
                chk($sformatf("u1 k%0d s%0d bubble", k, j), 32'(idex_bubble1), 32'd1);
                chk($sformatf("u1 k%0d s%0d stall_cnt", k, j), 32'(stall_cnt1),
                    32'(sat15(3 * k + j)));
                if (k == 0)
                    chk($sformatf("u1 s%0d stall_err", j), 32'(stall_err1), 32'd0);
            end
            cyc(1, 1, 3, 0, 1, 0, 4);
            chk($sformatf("u1 k%0d issue pc_wen", k), 32'(pc_wen1), 32'd1);
            chk($sformatf("u1 k%0d stall_err", k), 32'(stall_err1), 32'd1);
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("u1 saturated stall_cnt", 32'(stall_cnt1), 32'd15);
        chk("u1 sticky stall_err", 32'(stall_err1), 32'd1);

        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("u1 re-reset stall_cnt", 32'(stall_cnt1), 32'd0);
        chk("u1 re-reset stall_err", 32'(stall_err1), 32'd0);
        cyc(1, 1, 1, 1, 1, 1, 3);
        chk("u1 producer pc_wen", 32'(pc_wen1), 32'd1);
        cyc(1, 1, 7, 8, 1, 1, 6);
        chk("u1 independent pc_wen", 32'(pc_wen1), 32'd1);
        cyc(1, 1, 9, 3, 1, 1, 10);
        chk("u1 rt stall1 pc_wen", 32'(pc_wen1), 32'd0);
        cyc(1, 1, 9, 3, 1, 1, 10);
        chk("u1 rt stall2 pc_wen", 32'(pc_wen1), 32'd0);
        cyc(1, 1, 9, 3, 1, 1, 10);
        chk("u1 rt issue pc_wen", 32'(pc_wen1), 32'd1);
        chk("u1 rt stall_cnt", 32'(stall_cnt1), 32'd2);
        chk("u1 run at limit stall_err", 32'(stall_err1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
